// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : fixed-wait-state word RAM responder for the CPU load/store
//                 port (LDR/STR/LDRB/STRB), little-endian byte lanes.
//                 Optional macro: MEM_ALIGN_CHECK_EN (misaligned word -> rsp_err)
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_responder #(
  parameter int ADDR_WIDTH  = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [3:0]            wait_cnt;
  logic                  lat_wr;
  logic                  lat_byte;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [1:0]            lat_lane;
  logic [31:0]           lat_wdata;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0] mem [0:DEPTH-1];

  logic        accept;
  logic        misalign;
  logic        mem_we;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] rd_word;
  logic [31:0] rd_value;
  logic        unused_addr;

  // Address bits above the word index are don't-care: the array wraps.
  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = !lat_byte && (lat_lane != 2'd0);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      end
      // Counter sweeps 0..WAIT_CYCLES so accept-to-response is WAIT_CYCLES+2 edges.
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST)
          state_next = S_ACCESS;
      end
      S_ACCESS: state_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  assign accept = req_valid && (state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      lat_wr    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_idx   <= '0;
      lat_lane  <= 2'd0;
      lat_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_wr    <= req_wr;
        lat_byte  <= req_byte;
        lat_idx   <= req_addr[ADDR_WIDTH+1:2];
        lat_lane  <= req_addr[1:0];
        lat_wdata <= req_wdata;
        wait_cnt  <= 4'd0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (state == S_ACCESS) begin
        rdata_q <= (lat_wr || misalign) ? 32'd0 : rd_value;
        err_q   <= misalign;
      end
    end
  end

  assign byte_en  = lat_byte ? (4'b0001 << lat_lane) : 4'b1111;
  assign wr_lanes = lat_byte ? {4{lat_wdata[7:0]}} : lat_wdata;
  // An async reset forces state out of ACCESS, so an in-flight store is dropped.
  assign mem_we   = (state == S_ACCESS) && lat_wr && !misalign;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i])
          mem[lat_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign rd_word  = mem[lat_idx];
  assign rd_value = lat_byte ? {24'd0, rd_word[{lat_lane, 3'b000} +: 8]} : rd_word;

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed + randomized bench for mem_responder against a
//                    byte-addressed reference memory.
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_responder;

  localparam int          ADDR_WIDTH  = 18;
  localparam int          WAIT_CYCLES = 2;
  localparam int          LATENCY     = WAIT_CYCLES + 2;
  localparam logic [31:0] BYTE_MASK   = (32'd4 << ADDR_WIDTH) - 32'd1;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] bmem [int unsigned];

  mem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    int unsigned k = a & BYTE_MASK;
    return bmem.exists(k) ? bmem[k] : 8'h00;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input bit byt);
    logic [31:0] base = addr & ~32'd3;
    if (byt) return {24'd0, rd_byte(addr)};
    return {rd_byte(base + 3), rd_byte(base + 2), rd_byte(base + 1), rd_byte(base)};
  endfunction

  function automatic void model_store(input logic [31:0] addr, input bit byt,
                                      input logic [31:0] wdata);
    logic [31:0] base = addr & ~32'd3;
    if (byt) begin
      bmem[addr & BYTE_MASK] = wdata[7:0];
    end else begin
      for (int b = 0; b < 4; b++)
        bmem[(base + b) & BYTE_MASK] = wdata[8*b +: 8];
    end
  endfunction

  // One complete transaction; hold = cycles of response backpressure,
  // early = rsp_ready raised right after accept.
  task automatic txn(input string tag, input bit wr, input bit byt,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, input bit early);
    bit          exp_err;
    logic [31:0] exp_data;
    logic [31:0] held;
    int          k;
    exp_err  = ALIGN_EN && !byt && (addr[1:0] != 2'd0);
    exp_data = (wr || exp_err) ? 32'd0 : model_load(addr, byt);
    @(negedge clk);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    // Garbage on the request bus outside IDLE must be ignored.
    req_valid = 1'b0; req_wr = ~wr; req_byte = ~byt;
    req_addr = $urandom; req_wdata = $urandom;
    if (early) rsp_ready = 1'b1;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, ".latency"}, k, LATENCY);
    chk({tag, ".rdata"}, rsp_rdata, exp_data);
    chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    if (!early) begin
      held = rsp_rdata;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk); #1;
        chk({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".hold_rdata"}, rsp_rdata, held);
        chk({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".done_ready"}, {31'd0, req_ready}, 32'd1);
    if (wr && !exp_err) model_store(addr, byt, wdata);
  endtask

  logic [31:0] pool [8];

  initial begin
    #1;
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    txn("st_word", 1, 0, 32'h100, 32'hDEADBEEF, 0, 0);
    txn("ld_word", 0, 0, 32'h100, 32'h0, 0, 0);
    chk("ld_word.value", model_load(32'h100, 0), 32'hDEADBEEF);
    for (int i = 0; i < 4; i++)
      txn("ld_byte", 0, 1, 32'h100 + i, 32'h0, 0, 0);
    txn("st_byte", 1, 1, 32'h102, 32'hFFFFFF55, 0, 0);
    txn("ld_merged", 0, 0, 32'h100, 32'h0, 0, 0);
    chk("ld_merged.value", model_load(32'h100, 0), 32'hDE55BEEF);

    txn("st_wrap", 1, 0, 32'h00100100, 32'hCAFEF00D, 0, 0);
    txn("ld_wrap_bp", 0, 0, 32'h00000100, 32'h0, 5, 0);
    txn("ld_early_ready", 0, 0, 32'h00000100, 32'h0, 0, 1);

    // Interrupted store must not reach the array.
    txn("st_prior", 1, 0, 32'h200, 32'hAAAAAAAA, 0, 0);
    txn("ld_prior", 0, 0, 32'h200, 32'h0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_byte = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst.rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst.rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    txn("ld_after_rst", 0, 0, 32'h200, 32'h0, 0, 0);
    chk("ld_after_rst.value", model_load(32'h200, 0), 32'hAAAAAAAA);

    txn("st_misalign", 1, 0, 32'h101, 32'h11111111, 0, 0);
    txn("ld_misalign_chk", 0, 0, 32'h100, 32'h0, 0, 0);
    chk("misalign.value", model_load(32'h100, 0),
        ALIGN_EN ? 32'hDE55BEEF : 32'h11111111);
    txn("ld_misalign", 0, 0, 32'h102, 32'h0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'h400 + 32'(i * 4);
      txn("rnd_init", 1, 0, pool[i], $urandom, 0, 0);
    end
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3))
          | ($urandom & 32'hFFF0_0000);
      txn("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
